input_quant_packer: RTL and testbench

INPUT_QUANT_PACKER -- requirements
Module: input_quant_packer

---
 rtl/input_quant_packer.sv | 128 ++++++++++++
 tb/tb_input_quant_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/input_quant_packer.sv
// Quantizes raw features to 2-bit codes and packs N_FEATURES of them into one vector.
// Optional framing check on s_last: define INPUT_QUANT_PACKER_LAST_CHECK_EN.
`timescale 1ns/1ps
module input_quant_packer #(
  parameter int N_FEATURES = 8,
  parameter int W_IN       = 8,
  parameter int T0         = 64,
  parameter int T1         = 128,
  parameter int T2         = 192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [W_IN-1:0]         s_data,
  input  logic                    s_last,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*N_FEATURES-1:0] m_data,
  output logic [15:0]             vec_count,
  output logic                    frame_err
);

  localparam int IDX_W = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
  localparam logic [W_IN-1:0]  T0_W   = W_IN'(T0);
  localparam logic [W_IN-1:0]  T1_W   = W_IN'(T1);
  localparam logic [W_IN-1:0]  T2_W   = W_IN'(T2);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(N_FEATURES - 1);

  typedef enum logic {COLLECT, OUTPUT} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    s_ready_q;
  logic                    m_valid_q;
  logic [2*N_FEATURES-1:0] m_data_q;
  logic [2*N_FEATURES-1:0] m_data_d;
  logic [15:0]             vec_count_q;
  logic [1:0]              code_d;
  logic                    accept_d;
  logic                    at_end_d;
  logic                    drop_d;

  assign accept_d = s_valid && s_ready_q;
  assign at_end_d = (idx_q == IDX_END);

  always_comb begin
    code_d = 2'(s_data >= T0_W) + 2'(s_data >= T1_W) + 2'(s_data >= T2_W);
  end

  // Only the slot addressed by idx_q changes; all others keep their contents.
  genvar gi;
  generate
    for (gi = 0; gi < N_FEATURES; gi++) begin : g_slot
      assign m_data_d[2*gi +: 2] = (accept_d && idx_q == IDX_W'(gi)) ? code_d
                                                                      : m_data_q[2*gi +: 2];
    end
  endgenerate

`ifdef INPUT_QUANT_PACKER_LAST_CHECK_EN
  logic frame_err_q;

  // An early s_last throws the partial vector away instead of emitting it.
  assign drop_d = s_last && !at_end_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else if (accept_d && (s_last != at_end_d)) begin
      frame_err_q <= 1'b1;
    end
  end

  assign frame_err = frame_err_q;
`else
  logic unused_s_last;

  assign unused_s_last = s_last;
  assign drop_d        = 1'b0;
  assign frame_err     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      idx_q       <= '0;
      s_ready_q   <= 1'b1;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      vec_count_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept_d) begin
            m_data_q <= m_data_d;
            if (drop_d) begin
              idx_q <= '0;
            end else if (at_end_d) begin
              idx_q     <= '0;
              state_q   <= OUTPUT;
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (m_ready) begin
            state_q     <= COLLECT;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            vec_count_q <= vec_count_q + 16'd1;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_input_quant_packer.sv
// Scoreboard bench for input_quant_packer (N_FEATURES=4): stimulus pushes expected
// vectors, an independent monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_input_quant_packer;

  localparam int NF = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [2*NF-1:0] m_data;
  logic [15:0]   vec_count;
  logic          frame_err;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;
  logic [15:0] exp_vc;

  input_quant_packer #(.N_FEATURES(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .vec_count (vec_count),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: every handshake must match the oldest expected vector.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL vec_unexpected: got %0h expected none", m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("vec_data", 32'(m_data), 32'(mon_exp));
      end
    end
  end

  task automatic send_feature(input logic [7:0] x, input logic last);
    int n;
    s_valid = 1'b1;
    s_data  = x;
    s_last  = last;
    n = 0;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got s_ready=0 expected 1 for feature %0d", x);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    $display("sent feature %0d last=%0b", x, last);
  endtask

  task automatic wait_delivery(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_valid && m_ready) && n < 50);
    if (!(m_valid && m_ready)) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no handshake expected one", name);
    end
    @(posedge clk); #1;
    exp_vc = exp_vc + 16'd1;
    chk({name, "_vec_count"}, 32'(vec_count), 32'(exp_vc));
    chk({name, "_mvalid_low"}, 32'(m_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    exp_vc = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_vec_count", 32'(vec_count), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Back-to-back vector: codes 0,1,2,3
    m_ready = 1'b1;
    exp_q.push_back(8'b11_10_01_00);
    send_feature(8'd10, 1'b0);
    send_feature(8'd64, 1'b0);
    send_feature(8'd150, 1'b0);
    chk("pre_last_mvalid", 32'(m_valid), 32'd0);
    send_feature(8'd255, 1'b0);
    chk("latency_mvalid", 32'(m_valid), 32'd1);
    wait_delivery("basic");

    // Downstream stall for 5 cycles while upstream keeps offering junk
    m_ready = 1'b0;
    exp_q.push_back(8'b00_01_11_10);
    send_feature(8'd191, 1'b0);
    send_feature(8'd192, 1'b0);
    send_feature(8'd127, 1'b0);
    send_feature(8'd1, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      chk("stall_m_data", 32'(m_data), 32'h1E);
      chk("stall_m_valid", 32'(m_valid), 32'd1);
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      chk("stall_vec_count", 32'(vec_count), 32'(exp_vc));
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    wait_delivery("stall_release");
    exp_q.push_back(8'b11_11_01_00);
    send_feature(8'd63, 1'b0);
    send_feature(8'd64, 1'b0);
    send_feature(8'd255, 1'b0);
    send_feature(8'd254, 1'b0);
    wait_delivery("post_stall");

    // Asynchronous reset after two accepted features
    send_feature(8'd9, 1'b0);
    send_feature(8'd250, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_data", 32'(m_data), 32'd0);
    chk("midrst_vec_count", 32'(vec_count), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_vc = 16'd0;
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    exp_q.push_back(8'b00_10_00_11);
    send_feature(8'd200, 1'b0);
    send_feature(8'd0, 1'b0);
    send_feature(8'd128, 1'b0);
    send_feature(8'd63, 1'b0);
    wait_delivery("after_rst");

    // Counter wrap: preload 0xFFFF, two more deliveries land on 0x0001
    force dut.vec_count_q = 16'hFFFF;
    #1;
    release dut.vec_count_q;
    exp_vc = 16'hFFFF;
    exp_q.push_back(8'b11_10_01_00);
    send_feature(8'd10, 1'b0);
    send_feature(8'd64, 1'b0);
    send_feature(8'd150, 1'b0);
    send_feature(8'd255, 1'b0);
    wait_delivery("wrap_ffff");
    exp_q.push_back(8'b00_10_00_11);
    send_feature(8'd200, 1'b0);
    send_feature(8'd0, 1'b0);
    send_feature(8'd128, 1'b0);
    send_feature(8'd63, 1'b0);
    wait_delivery("wrap_65537");

    // Early s_last on 2nd feature, then a correct 4-feature frame
`ifdef INPUT_QUANT_PACKER_LAST_CHECK_EN
    exp_q.push_back(8'b10_00_01_11);
`else
    exp_q.push_back(8'b01_11_10_11);
`endif
    send_feature(8'd200, 1'b0);
    send_feature(8'd130, 1'b1);
    chk("frame_no_mvalid", 32'(m_valid), 32'd0);
`ifdef INPUT_QUANT_PACKER_LAST_CHECK_EN
    chk("frame_err_set", 32'(frame_err), 32'd1);
`else
    chk("frame_err_tied", 32'(frame_err), 32'd0);
`endif
    send_feature(8'd192, 1'b0);
    send_feature(8'd65, 1'b0);
`ifdef INPUT_QUANT_PACKER_LAST_CHECK_EN
    send_feature(8'd0, 1'b0);
    send_feature(8'd140, 1'b1);
    wait_delivery("frame_next");
    chk("frame_err_sticky", 32'(frame_err), 32'd1);
`else
    wait_delivery("frame_count");
    send_feature(8'd0, 1'b0);
    send_feature(8'd140, 1'b1);
    chk("frame_partial_mvalid", 32'(m_valid), 32'd0);
    chk("frame_err_still0", 32'(frame_err), 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
